seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Time-multiplexed driver for the board's eight-digit common-anode seven-segment display.
- Consumes register contents such as the shift-register q, zero-extended into the data word, and replaces the constant all-off anode drive at the top level.
- Captures a frame-coherent snapshot of eight hex nibbles, decimal points and digit enables, then scans digits with per-slot ghost blanking.
- Runs on the 100 MHz board clock with an internal prescaler; no divided clock is needed.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot; 100 MHz gives a 1 kHz digit rate and a 125 Hz frame rate. Must be >= 2.
- BLANK, 16: cycles at the start of each slot with all anodes off (anti-ghosting). Legal range is 1 <= BLANK < SCAN_DIV.

Ports:
- clk  input  1  board clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- data  input  32  eight hex nibbles; data[4k+3:4k] is digit k, and digit 0 is the rightmost.
- dp_in  input  8  decimal-point request per digit, active-high.
- en_mask  input  8  digit enable per digit, active-high; a disabled digit stays dark.
- anode  output  8  digit select, active-low; anode[k] drives digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1 at an edge:
  - anode <= 8'hFF, seg <= 7'h7F, dp <= 1.
  - cnt <= 0, dig <= 0.
  - Snapshot registers (snap_data, snap_dp, snap_mask) <= 0.
  - Reset asserted mid-slot or mid-frame has the same effect; no partial state survives.
- Slot counter cnt, width clog2(SCAN_DIV), and digit index dig, 3 bits, advance on every non-reset edge:
  - If cnt == SCAN_DIV-1: cnt <= 0 and dig <= dig+1. dig wraps 7 -> 0 with no extra cycle.
  - Otherwise: cnt <= cnt+1.
- Snapshot:
  - When cnt==0 and dig==0 (first cycle of each frame, including the first cycle after reset release), load snap_data <= data, snap_dp <= dp_in, snap_mask <= en_mask.
  - Input changes at any other time are ignored until the next frame start. The display never tears within a frame.
- Output registers have one cycle of latency and are computed from the pre-edge cnt, dig and snapshot values:
  - If cnt < BLANK: anode=FF, seg=7F, dp=1. This covers the snapshot-load cycle, so stale snapshot data never reaches the pins.
  - Else if snap_mask[dig]=0: anode=FF, seg=7F, dp=1.
  - Else: anode = ~(8'h01 << dig), seg = decode(snap_data nibble dig), dp = ~snap_dp[dig].
- Decode table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariants:
  - At most one anode bit is low in any cycle.
  - Each digit is lit for exactly SCAN_DIV-BLANK consecutive cycles per frame when enabled.
  - Frame length is exactly 8*SCAN_DIV cycles.
- There is no handshake. Inputs are level-sampled at frame start only and may change asynchronously relative to slots, but must be synchronous to clk.

Test Plan (bench parameters SCAN_DIV=8, BLANK=2; "edge n" counts rising edges after rst is deasserted, with edge 1 being the first edge where rst=0):
- Reset: hold rst=1 for 3 edges with data=FFFFFFFF and mask=FF -> anode=FF, seg=7F, dp=1. After release, edges 1-2 stay blanked.
- Scan and decode: data=76543210, mask=FF, dp_in=00 -> edges 3-8: anode=FE, seg=40. Edges 9-10: blank. Edges 11-16: anode=FD, seg=79. Digit 7 (edges 59-64): anode=7F, seg=78. Edge 65: blank, and the frame repeats.
- Masking: mask=01 -> anode is FE for 6 of every 64 edges and FF otherwise; never any other value.
- Frame coherence:
  - data=00000000 at reset release; change to 88888888 at edge 20 -> all digits in frame 0 still show seg=40.
  - Digit 0 of frame 1 (edges 67-72) shows seg=00.
- Decimal point: dp_in=80, mask=FF -> dp=0 only on edges 59-64 (digit 7 lit window); dp=1 elsewhere.
- Reset mid-operation: assert rst for 1 edge during digit 5 lit window -> that edge gives anode=FF, seg=7F, dp=1. After release, the scan restarts at digit 0 (anode=FE on edges 3-8) with a fresh snapshot.

Source files
------------

// File: rtl/seg_scan.sv
// Time-multiplexed driver for an eight-digit common-anode seven-segment display.
// Snapshots data/dp/enables once per frame and scans the digits with per-slot blanking.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_mask,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [2:0]    dig;
  logic [31:0]   snap_data;
  logic [7:0]    snap_dp;
  logic [7:0]    snap_mask;

  logic          frame_start_c;
  logic [3:0]    nib_c;
  logic [7:0]    anode_nxt_c;
  logic [6:0]    seg_nxt_c;
  logic          dp_nxt_c;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign frame_start_c = (cnt == '0) && (dig == 3'd0);
  assign nib_c         = snap_data[{dig, 2'b00} +: 4];

  // Next pin state from pre-edge counters and snapshot; the blank window covers the load cycle.
  always_comb begin
    anode_nxt_c = 8'hFF;
    seg_nxt_c   = 7'h7F;
    dp_nxt_c    = 1'b1;
    if ((cnt >= CNT_BLANK) && snap_mask[dig]) begin
      anode_nxt_c = ~(8'h01 << dig);
      seg_nxt_c   = decode(nib_c);
      dp_nxt_c    = ~snap_dp[dig];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dig       <= 3'd0;
      snap_data <= 32'h0;
      snap_dp   <= 8'h0;
      snap_mask <= 8'h0;
      anode     <= 8'hFF;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        dig <= dig + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_start_c) begin
        snap_data <= data;
        snap_dp   <= dp_in;
        snap_mask <= en_mask;
      end
      anode <= anode_nxt_c;
      seg   <= seg_nxt_c;
      dp    <= dp_nxt_c;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with SCAN_DIV=8, BLANK=2.
module tb_seg_scan;

  localparam int unsigned SCAN_DIV = 8;
  localparam int unsigned BLANK    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp_in;
  logic [7:0]  en_mask;
  logic [7:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  seg_scan #(.SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
    .clk     (clk),
    .rst     (rst),
    .data    (data),
    .dp_in   (dp_in),
    .en_mask (en_mask),
    .anode   (anode),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  initial begin
    int unsigned fe_count;
    int unsigned slot;
    int unsigned c;
    logic [7:0]  exp_an;

    // Reset with inputs that would light everything if not held off.
    data    = 32'hFFFF_FFFF;
    dp_in   = 8'hFF;
    en_mask = 8'hFF;
    do_reset(3);
    check("reset_anode", 32'(anode), 32'hFF);
    check("reset_seg",   32'(seg),   32'h7F);
    check("reset_dp",    32'(dp),    32'h1);

    // Scan and decode over one frame plus the next digit 0.
    data  = 32'h7654_3210;
    dp_in = 8'h00;
    do_reset(1);
    for (int n = 1; n <= 72; n++) begin
      step();
      slot = ((n - 1) / SCAN_DIV) % 8;
      c    = (n - 1) % SCAN_DIV;
      if (c < BLANK) begin
        check($sformatf("scan_anode_e%0d", n), 32'(anode), 32'hFF);
        check($sformatf("scan_seg_e%0d", n),   32'(seg),   32'h7F);
      end else begin
        exp_an = ~(8'h01 << slot);
        check($sformatf("scan_anode_e%0d", n), 32'(anode), 32'(exp_an));
        check($sformatf("scan_seg_e%0d", n),   32'(seg),   32'(seg_of(4'(slot))));
      end
      check($sformatf("scan_dp_e%0d", n), 32'(dp), 32'h1);
      if (n == 3)  begin check("e3_anode", 32'(anode), 32'hFE); check("e3_seg", 32'(seg), 32'h40); end
      if (n == 11) begin check("e11_anode", 32'(anode), 32'hFD); check("e11_seg", 32'(seg), 32'h79); end
      if (n == 64) begin check("e64_anode", 32'(anode), 32'h7F); check("e64_seg", 32'(seg), 32'h78); end
      if (n == 65) check("e65_anode", 32'(anode), 32'hFF);
    end

    // Only digit 0 enabled: FE for 6 of every 64 edges, FF otherwise.
    en_mask  = 8'h01;
    fe_count = 0;
    do_reset(1);
    for (int n = 1; n <= 128; n++) begin
      step();
      slot   = ((n - 1) / SCAN_DIV) % 8;
      c      = (n - 1) % SCAN_DIV;
      exp_an = (slot == 0 && c >= BLANK) ? 8'hFE : 8'hFF;
      check($sformatf("mask_anode_e%0d", n), 32'(anode), 32'(exp_an));
      if (anode == 8'hFE) fe_count++;
    end
    check("mask_fe_count", 32'(fe_count), 32'd12);

    // Input change mid-frame must wait for the next frame start.
    data    = 32'h0000_0000;
    en_mask = 8'hFF;
    do_reset(1);
    for (int n = 1; n <= 72; n++) begin
      step();
      c = (n - 1) % SCAN_DIV;
      if (c >= BLANK)
        check($sformatf("coh_seg_e%0d", n), 32'(seg), (n <= 64) ? 32'h40 : 32'h00);
      if (n == 20) data = 32'h8888_8888;
    end

    // Decimal point on digit 7 only.
    data  = 32'h7654_3210;
    dp_in = 8'h80;
    do_reset(1);
    for (int n = 1; n <= 66; n++) begin
      step();
      check($sformatf("dp_e%0d", n), 32'(dp), (n >= 59 && n <= 64) ? 32'h0 : 32'h1);
    end

    // Reset in digit 5's lit window, then a clean restart with a new snapshot.
    dp_in = 8'h00;
    do_reset(1);
    repeat (44) step();
    check("pre_rst_anode", 32'(anode), 32'hDF);
    data = 32'h1111_1111;
    do_reset(1);
    check("midrst_anode", 32'(anode), 32'hFF);
    check("midrst_seg",   32'(seg),   32'h7F);
    check("midrst_dp",    32'(dp),    32'h1);
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n >= 3 && n <= 8) begin
        check($sformatf("restart_anode_e%0d", n), 32'(anode), 32'hFE);
        check($sformatf("restart_seg_e%0d", n),   32'(seg),   32'h79);
      end else begin
        check($sformatf("restart_anode_e%0d", n), 32'(anode), 32'hFF);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
